i2c_bus_arbiter: RTL
====================

Name: i2c_bus_arbiter

Overview:
- Shares one i2c_wrapper master port between NUM_REQ configuration requesters, for example the IT6263 HDMI config sequencer and a camera sensor config sequencer.
- Arbitration is round-robin at transaction granularity. A grant is held from the first byte until the wrapper reports the stop condition, followed by an enforced bus-free gap.
- Sits between the config sequencers and i2c_wrapper in the same i_sysclk domain.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
GAP_CYC, 25, idle cycles between transactions (1 us at 25 MHz)
TIMEOUT_CYC, 250000, cycles without progress before abort (10 ms at 25 MHz); used only with I2C_ARB_TIMEOUT_EN
CNT_W, 18, width of the gap/timeout counter; must hold max(GAP_CYC, TIMEOUT_CYC)

Ports:
i_sysclk  in  1  system clock; all logic on its rising edge
i_arst  in  1  reset, synchronous, active-high
i_req_en  in  NUM_REQ  per-requester enable (same meaning as i2c_wrapper i_m_en)
i_req_wr  in  NUM_REQ  per-requester write/read select
i_req_last  in  NUM_REQ  per-requester end-of-transaction pulse
i_req_addr  in  7*NUM_REQ  packed 7-bit device addresses; requester k uses bits [7k+6:7k]
i_req_data  in  8*NUM_REQ  packed write data; requester k uses bits [8k+7:8k]
o_req_ack  out  NUM_REQ  byte ack, routed to the grantee only
o_req_last  out  NUM_REQ  wrapper last, routed to the grantee only
o_req_data  out  8  read data, broadcast to all requesters
o_gnt  out  NUM_REQ  one-hot grant, registered
o_busy  out  1  high in every state except s_IDLE
o_timeout  out  NUM_REQ  sticky abort flag per requester
o_m_en, o_m_wr, o_m_last  out  1 each  to wrapper i_m_en, i_m_wr, i_last
o_m_addr  out  7  to wrapper i_addr
o_m_data  out  8  to wrapper i_data
i_m_ack, i_m_last  in  1 each  from wrapper o_ack, o_last (o_last = stop completed)
i_m_data  in  8  from wrapper o_data

Behaviour:
- Reset: state s_IDLE, round-robin pointer r_ptr=0, counter=0. All outputs 0, including o_gnt, o_busy and o_timeout.
  - Reset asserted mid-transaction drives o_m_en=0 on the next edge. No last pulse is issued.
- States: s_IDLE, s_GRANT, s_STOP, s_GAP.
- s_IDLE:
  - If any i_req_en bit is high, pick the first set bit searching upward from r_ptr, wrapping modulo NUM_REQ.
  - Next edge: o_gnt=onehot(g), state s_GRANT.
  - Latency: request seen at edge N gives o_gnt and o_m_en high from edge N+1.
  - Simultaneous requests after reset: requester 0 wins.
- s_GRANT:
  - Combinational mux: o_m_en = i_req_en[g], o_m_wr = i_req_wr[g], o_m_last = i_req_last[g], o_m_addr and o_m_data from slice g.
  - o_req_ack[g] = i_m_ack and o_req_last[g] = i_m_last. Non-grantees see 0.
  - The grantee dropping en without last is a pause; the grant is held.
  - i_req_last[g]=1 moves the state to s_STOP on the next edge.
- s_STOP:
  - o_m_en and o_m_last forced 0. This blocks a grantee that re-raises en immediately.
  - On i_m_last=1: go to s_GAP, clear the counter, and set r_ptr = (g+1) mod NUM_REQ.
- s_GAP:
  - o_gnt=0, all master outputs 0. Counter increments each cycle.
  - At counter == GAP_CYC-1: go to s_IDLE.
  - Requests arriving during the gap are held pending and are not lost; requesters keep en high.
- Master outputs outside s_GRANT are all 0.
- Starvation bound: a requester waits at most NUM_REQ-1 transactions.
- o_req_data is i_m_data passed straight through.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- When defined, a progress counter runs in s_GRANT and s_STOP. It clears on grant, on every i_m_ack, and on state entry.
- Timeout in s_GRANT (counter == TIMEOUT_CYC-1):
  - One-cycle o_m_last=1 with o_m_en=0.
  - o_timeout[g] set (sticky until reset).
  - Next state s_STOP.
- Timeout in s_STOP: next state s_GAP without waiting for i_m_last, with r_ptr advanced.
- When undefined: no timeout counter logic, o_timeout tied to 0, and grants hold indefinitely.

Test Plan:
- Single requester, with NUM_REQ=2 and GAP_CYC=25:
  - Stimulus: req0 writes 2 bytes (wrapper acks byte 0 at +5 and byte 1 at +10), pulses last, then i_m_last at +20.
  - Response: o_gnt=01 one cycle after en. o_req_ack[0] mirrors the acks. o_busy falls exactly 25 cycles after i_m_last.
- Simultaneous requests:
  - Stimulus: req0 and req1 raise en on the same cycle after reset.
  - Response: grant order 0,1,0,1 over four back-to-back transactions. o_req_ack[1] stays 0 while o_gnt=01.
- Immediate re-raise:
  - Stimulus: req0 raises en the cycle after its last pulse.
  - Response: o_m_en stays 0 through s_STOP and s_GAP. If req1 is pending, req1 is granted next.
- Reset mid-transfer:
  - Stimulus: assert i_arst for 1 cycle while in s_GRANT with o_m_en=1.
  - Response: next edge shows o_m_en=0, o_gnt=0, state s_IDLE, r_ptr=0.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYC=100):
  - Stimulus: grantee holds en and i_m_ack never arrives.
  - Response: o_m_last pulses at cycle 100 after grant, o_timeout=01, then s_STOP.
  - Stimulus: i_m_last also absent.
  - Response: s_GAP entered 100 cycles later.
- Build without I2C_ARB_TIMEOUT_EN:
  - Stimulus: same stall as the timeout scenario, held 10^6 cycles.
  - Response: grant held, o_timeout=00.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter
// Desc     : Round-robin sharing of one i2c_wrapper master port between
//            NUM_REQ config sequencers; stall abort under I2C_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int GAP_CYC     = 25,
  parameter int TIMEOUT_CYC = 250000,
  parameter int CNT_W       = 18
) (
  input  logic                   i_sysclk,
  input  logic                   i_arst,
  input  logic [NUM_REQ-1:0]     i_req_en,
  input  logic [NUM_REQ-1:0]     i_req_wr,
  input  logic [NUM_REQ-1:0]     i_req_last,
  input  logic [7*NUM_REQ-1:0]   i_req_addr,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]     o_req_ack,
  output logic [NUM_REQ-1:0]     o_req_last,
  output logic [7:0]             o_req_data,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic                   o_busy,
  output logic [NUM_REQ-1:0]     o_timeout,
  output logic                   o_m_en,
  output logic                   o_m_wr,
  output logic                   o_m_last,
  output logic [6:0]             o_m_addr,
  output logic [7:0]             o_m_data,
  input  logic                   i_m_ack,
  input  logic                   i_m_last,
  input  logic [7:0]             i_m_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   c_GAP_END  = CNT_W'(GAP_CYC - 1);
  localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);

  if ((NUM_REQ < 2) || (NUM_REQ > 4) || (GAP_CYC < 1) || (TIMEOUT_CYC < 1) ||
      (((GAP_CYC - 1) >> CNT_W) != 0) || (((TIMEOUT_CYC - 1) >> CNT_W) != 0))
  begin : g_param_check
    $error("i2c_bus_arbiter: illegal NUM_REQ/GAP_CYC/TIMEOUT_CYC/CNT_W combination");
  end

  typedef enum logic [1:0] {
    s_IDLE  = 2'd0,
    s_GRANT = 2'd1,
    s_STOP  = 2'd2,
    s_GAP   = 2'd3
  } state_t;

  state_t               r_state_q;
  logic [IDX_W-1:0]     r_ptr_q;
  logic [IDX_W-1:0]     r_gidx_q;
  logic [NUM_REQ-1:0]   r_gnt_q;
  logic [CNT_W-1:0]     r_cnt_q;
  logic [IDX_W-1:0]     w_pick;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_tmo_hit;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_TMO_END = CNT_W'(TIMEOUT_CYC - 1);
  logic [NUM_REQ-1:0] r_tmo_q;
  assign w_tmo_hit = ((r_state_q == s_GRANT) || (r_state_q == s_STOP)) &&
                     (r_cnt_q == c_TMO_END);
  assign o_timeout = r_tmo_q;
`else
  assign w_tmo_hit = 1'b0;
  assign o_timeout = '0;
`endif

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    w_pick = r_ptr_q;
    w_cand = r_ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_cand = IDX_W'((int'(r_ptr_q) + i) % NUM_REQ);
      if (i_req_en[w_cand]) w_pick = w_cand;
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      r_state_q <= s_IDLE;
      r_ptr_q   <= '0;
      r_gidx_q  <= '0;
      r_gnt_q   <= '0;
      r_cnt_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_tmo_q   <= '0;
`endif
    end else begin
      case (r_state_q)
        s_IDLE: begin
          if (|i_req_en) begin
            r_gidx_q  <= w_pick;
            r_gnt_q   <= c_ONE << w_pick;
            r_cnt_q   <= '0;
            r_state_q <= s_GRANT;
          end
        end
        s_GRANT: begin
`ifdef I2C_ARB_TIMEOUT_EN
          if (w_tmo_hit) r_tmo_q[r_gidx_q] <= 1'b1;
          if (w_tmo_hit || i_req_last[r_gidx_q]) begin
            r_cnt_q   <= '0;
            r_state_q <= s_STOP;
          end else if (i_m_ack) begin
            r_cnt_q <= '0;
          end else begin
            r_cnt_q <= r_cnt_q + 1'b1;
          end
`else
          if (i_req_last[r_gidx_q]) r_state_q <= s_STOP;
`endif
        end
        s_STOP: begin
          if (i_m_last || w_tmo_hit) begin
            r_state_q <= s_GAP;
            r_cnt_q   <= '0;
            r_gnt_q   <= '0;
            r_ptr_q   <= (r_gidx_q == c_LAST_IDX) ? '0 : r_gidx_q + 1'b1;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (i_m_ack) r_cnt_q <= '0;
          else              r_cnt_q <= r_cnt_q + 1'b1;
`endif
        end
        s_GAP: begin
          if (r_cnt_q == c_GAP_END) begin
            r_state_q <= s_IDLE;
            r_cnt_q   <= '0;
          end else begin
            r_cnt_q <= r_cnt_q + 1'b1;
          end
        end
        default: r_state_q <= s_IDLE;
      endcase
    end
  end

  // A stall abort presents last without en so the wrapper issues a bare stop.
  always_comb begin
    o_m_en   = 1'b0;
    o_m_wr   = 1'b0;
    o_m_last = 1'b0;
    o_m_addr = '0;
    o_m_data = '0;
    if (r_state_q == s_GRANT) begin
      o_m_en   = i_req_en[r_gidx_q] & ~w_tmo_hit;
      o_m_wr   = i_req_wr[r_gidx_q];
      o_m_last = i_req_last[r_gidx_q] | w_tmo_hit;
      o_m_addr = i_req_addr[int'(r_gidx_q) * 7 +: 7];
      o_m_data = i_req_data[int'(r_gidx_q) * 8 +: 8];
    end
  end

  assign o_gnt      = r_gnt_q;
  assign o_busy     = (r_state_q != s_IDLE);
  assign o_req_ack  = r_gnt_q & {NUM_REQ{i_m_ack}};
  assign o_req_last = r_gnt_q & {NUM_REQ{i_m_last}};
  assign o_req_data = i_m_data;

endmodule
`default_nettype wire
